decade_freq_ctrl: RTL and testbench
===================================

# decade_freq_ctrl

Controller that sequences a cascade of four mod-10 (BCD) counter stages to generate selectable output frequencies of clk_i/10, /100, /1000 and /10000. It owns start/stop of the decade chain and applies frequency-selection changes glitch-free at a period boundary via a valid/ready handshake. It sits between the board-level control logic (buttons/switch decoder) and the frequency output and display paths.

## Interface
- DEFAULT_SEL, 0: selection loaded at reset (0..3).
- clk_i  in  1  FPGA system clock.
- reset  in  1  synchronous, active-high; clock clk_i.
- start_i  in  1  single-cycle start request; honoured only in IDLE.
- stop_i  in  1  single-cycle stop request; honoured in RUN and PEND.
- sel_i  in  2  requested divide exponent minus one: N = 10^(sel_i+1).
- sel_valid_i  in  1  sel_i is valid this cycle.
- sel_ready_o  out  1  controller can accept a selection; transfer when sel_valid_i & sel_ready_o.
- tick_o  out  1  one-cycle pulse at the terminal count of the selected span.
- freq_o  out  1  square wave, toggles after each tick_o, period 2N cycles.
- busy_o  out  1  high in RUN and PEND.
- cur_sel_o  out  2  selection currently in effect.
- count_o  out  16  BCD digits {d3,d2,d1,d0}, each 0..9.

## Operation
- States: IDLE, RUN, PEND. Reset -> IDLE, cur_sel=DEFAULT_SEL, all digits 0, freq_o=0, tick_o=0, busy_o=0, sel_ready_o=1.
- Decade chain: counts only in RUN/PEND. d0 increments every cycle; dk increments when d0..d(k-1) all equal 9; every digit wraps 9->0. In IDLE all digits held at 0.
- tick_o = busy & (d0..d(cur_sel) all equal 9); combinational from registered state/digits.
- freq_o: registered; toggles at the edge ending each tick_o cycle; forced 0 in IDLE.
- IDLE: sel_ready_o=1; accepted sel updates cur_sel next cycle. start_i -> RUN. start_i and sel_valid_i together: both take effect (RUN with new sel). stop_i ignored.
- RUN: sel_ready_o=1; accepted sel stored in pend_sel -> PEND. Selection equal to cur_sel still goes through PEND. start_i ignored.
- PEND: sel_ready_o=0. On a tick_o cycle: cur_sel<=pend_sel, all digits cleared to 0, freq_o toggles normally, -> RUN.
- stop_i in RUN/PEND: -> IDLE next cycle, digits cleared, freq_o=0, pend_sel discarded. stop_i has priority over sel_valid_i, start_i and a same-cycle tick (freq_o does not toggle; it goes to 0).
- Accepted sel in RUN on a tick_o cycle: that tick is a normal tick under the old selection; the switch happens at the next tick.

## Timing
- Start: start_i sampled at edge E; digits=0 in the first cycle after E (cycle 0); first tick_o in cycle N-1; then every N cycles.
- freq_o first rises at the edge ending cycle N-1; half-period N, period 2N.
- Selection switch: the new half-period after the switch tick is exactly N_new cycles; no runt or stretched half-period beyond the old N_old.
- Worst-case selection latency: N_old cycles from acceptance to cur_sel_o update.
- stop_i: busy_o, freq_o, count_o go to 0 one cycle after the sampling edge.
- Reset mid-operation overrides everything; outputs take reset values the cycle after.

## Test plan
- Reset then idle 50 cycles -> tick_o=0, freq_o=0, count_o=16'h0000, sel_ready_o=1, cur_sel_o=DEFAULT_SEL.
- sel=0, start -> tick_o in cycles 9,19,29,...; freq_o period 20; count_o d0 cycles 0..9.
- sel=1, run 1000 cycles -> tick_o every 100 cycles, count_o d1d0 reaching 99 on tick; d2 increments after each tick (no tick dependence on d2).
- In RUN sel=0, present sel=2 at cycle 4 -> sel_ready_o low until tick at cycle 9; cur_sel_o=2 from cycle 10; next tick at cycle 1009; freq_o half-periods 10 then 1000.
- stop_i asserted in same cycle as tick_o while PEND -> IDLE next cycle, freq_o=0, count_o=0, cur_sel_o unchanged, sel_ready_o=1.
- Assert reset in PEND -> all outputs at reset values next cycle; subsequent start runs with DEFAULT_SEL.

Source files
------------

// File: rtl/decade_freq_ctrl.sv
// Frequency divider controller: a four-stage BCD decade chain with start/stop
// and glitch-free selection of clk_i/10 .. clk_i/10000 at a period boundary.
module decade_freq_ctrl #(
    parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [1:0]  sel_i,
    input  logic        sel_valid_i,
    output logic        sel_ready_o,
    output logic        tick_o,
    output logic        freq_o,
    output logic        busy_o,
    output logic [1:0]  cur_sel_o,
    output logic [15:0] count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [1:0]       cur_sel, cur_sel_next;
    logic [1:0]       pend_sel, pend_sel_next;
    logic [3:0][3:0]  digits;
    logic [3:0]       nine;
    logic [3:0]       span_nine;
    logic [3:0]       carry;
    logic             busy;
    logic             tick;
    logic             clear;
    logic             freq;

    // span_nine[k]: digits 0..k all at 9, i.e. the span of exponent k is at terminal count
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nine[k] = (digits[k] == 4'd9);
        end
        span_nine[0] = nine[0];
        for (int k = 1; k < 4; k++) begin
            span_nine[k] = span_nine[k-1] & nine[k];
        end
        carry = {span_nine[2:0], 1'b1};
    end

    assign busy = (state != IDLE);
    assign tick = busy & span_nine[cur_sel];

    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_next    = state;
        cur_sel_next  = cur_sel;
        pend_sel_next = pend_sel;
        clear         = 1'b0;
        unique case (state)
            IDLE: begin
                clear = 1'b1;
                if (sel_valid_i) cur_sel_next = sel_i;
                if (start_i)     state_next   = RUN;
            end
            RUN: begin
                if (stop_i) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (sel_valid_i) begin
                    pend_sel_next = sel_i;
                    state_next    = PEND;
                end
            end
            PEND: begin
                // Switch only on the terminal count so no half-period is cut short
                if (stop_i) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (tick) begin
                    cur_sel_next = pend_sel;
                    clear        = 1'b1;
                    state_next   = RUN;
                end
            end
            default: begin
                state_next = IDLE;
                clear      = 1'b1;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state    <= IDLE;
            cur_sel  <= DEFAULT_SEL;
            pend_sel <= DEFAULT_SEL;
        end else begin
            state    <= state_next;
            cur_sel  <= cur_sel_next;
            pend_sel <= pend_sel_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset || clear) begin
            digits <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (carry[k]) digits[k] <= nine[k] ? 4'd0 : digits[k] + 4'd1;
            end
        end
    end

    // Stop wins over a same-cycle tick: output drops to 0 instead of toggling
    always_ff @(posedge clk_i) begin
        if (reset || !busy || stop_i) begin
            freq <= 1'b0;
        end else if (tick) begin
            freq <= ~freq;
        end
    end

    assign sel_ready_o = (state != PEND);
    assign tick_o      = tick;
    assign freq_o      = freq;
    assign busy_o      = busy;
    assign cur_sel_o   = cur_sel;
    assign count_o     = digits;

endmodule

// File: tb/tb_decade_freq_ctrl.sv
// Scoreboard bench for decade_freq_ctrl: a cycle-count reference model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_decade_freq_ctrl;

    localparam logic [1:0] DEF_SEL = 2'd0;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        start_i;
    logic        stop_i;
    logic [1:0]  sel_i;
    logic        sel_valid_i;
    logic        sel_ready_o;
    logic        tick_o;
    logic        freq_o;
    logic        busy_o;
    logic [1:0]  cur_sel_o;
    logic [15:0] count_o;

    always #5 clk_i = ~clk_i;

    decade_freq_ctrl #(.DEFAULT_SEL(DEF_SEL)) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .sel_i       (sel_i),
        .sel_valid_i (sel_valid_i),
        .sel_ready_o (sel_ready_o),
        .tick_o      (tick_o),
        .freq_o      (freq_o),
        .busy_o      (busy_o),
        .cur_sel_o   (cur_sel_o),
        .count_o     (count_o)
    );

    typedef struct {
        logic        tick;
        logic        freq;
        logic        busy;
        logic        ready;
        logic [1:0]  cur;
        logic [15:0] count;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: elapsed cycles since start/switch instead of BCD digits
    bit         m_busy;
    bit         m_pend;
    bit         m_freq;
    logic [1:0] m_cur;
    logic [1:0] m_pend_sel;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int span(input logic [1:0] s);
        case (s)
            2'd0:    return 10;
            2'd1:    return 100;
            2'd2:    return 1000;
            default: return 10000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit m_tick();
        return m_busy && (m_cnt % span(m_cur) == span(m_cur) - 1);
    endfunction

    task automatic model_reset();
        m_busy     = 1'b0;
        m_pend     = 1'b0;
        m_freq     = 1'b0;
        m_cur      = DEF_SEL;
        m_pend_sel = DEF_SEL;
        m_cnt      = 0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model
    task automatic cyc(input bit st, input bit sp, input logic [1:0] s, input bit v, input bit rst);
        exp_t e;
        bit   t;
        start_i     = st;
        stop_i      = sp;
        sel_i       = s;
        sel_valid_i = v;
        reset       = rst;
        t       = m_tick();
        e.tick  = t;
        e.freq  = m_freq;
        e.busy  = m_busy;
        e.ready = !m_pend;
        e.cur   = m_cur;
        e.count = to_bcd(m_cnt);
        sb_q.push_back(e);
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (v)  m_cur  = s;
            if (st) m_busy = 1'b1;
            m_cnt  = 0;
            m_freq = 1'b0;
        end else if (sp) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_freq = 1'b0;
        end else begin
            if (t) m_freq = !m_freq;
            if (m_pend && t) begin
                m_cur  = m_pend_sel;
                m_pend = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 10000;
                if (!m_pend && v) begin
                    m_pend     = 1'b1;
                    m_pend_sel = s;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 0, 0);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("tick_o",      32'(tick_o),      32'(e.tick));
            check("freq_o",      32'(freq_o),      32'(e.freq));
            check("busy_o",      32'(busy_o),      32'(e.busy));
            check("sel_ready_o", 32'(sel_ready_o), 32'(e.ready));
            check("cur_sel_o",   32'(cur_sel_o),   32'(e.cur));
            check("count_o",     32'(count_o),     32'(e.count));
        end
    end

    initial begin
        reset       = 1'b1;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        sel_i       = 2'd0;
        sel_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_reset();

        // Reset values held through an idle stretch; stop ignored in IDLE
        idle(50);
        cyc(0, 1, 2'd0, 0, 0);

        // /10: start with selection in the same cycle, ticks at 9, 19, ...
        cyc(1, 0, 2'd0, 1, 0);
        idle(60);
        cyc(0, 1, 2'd0, 0, 0);
        idle(3);

        // /100 for 1000 cycles, selection loaded while idle
        cyc(0, 0, 2'd1, 1, 0);
        cyc(1, 0, 2'd0, 0, 0);
        idle(1000);
        cyc(0, 1, 2'd0, 0, 0);
        idle(2);

        // /10 -> /1000 requested at cycle 4, switch at tick 9, next tick at 1009
        cyc(1, 0, 2'd0, 1, 0);
        idle(4);
        cyc(0, 0, 2'd2, 1, 0);
        cyc(0, 0, 2'd3, 1, 0);
        idle(2100);
        cyc(0, 1, 2'd0, 0, 0);
        idle(2);

        // Selection accepted on a tick cycle switches at the following tick
        cyc(1, 0, 2'd0, 1, 0);
        idle(9);
        cyc(0, 0, 2'd1, 1, 0);
        idle(130);
        cyc(0, 1, 2'd0, 0, 0);

        // Stop on the same cycle as a tick while PEND
        cyc(1, 0, 2'd0, 1, 0);
        idle(3);
        cyc(0, 0, 2'd1, 1, 0);
        idle(5);
        cyc(0, 1, 2'd0, 0, 0);
        idle(5);

        // Reset while PEND, then restart under the default selection
        cyc(1, 0, 2'd3, 1, 0);
        idle(2);
        cyc(0, 0, 2'd2, 1, 0);
        idle(2);
        cyc(0, 0, 2'd0, 0, 1);
        idle(3);
        cyc(1, 0, 2'd0, 0, 0);
        idle(30);

        // Random control traffic, including start+stop and rare resets
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(19) == 0, $urandom_range(199) == 0, 2'($urandom_range(3)),
                $urandom_range(29) == 0, $urandom_range(999) == 0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
